// File: rtl/button_event_counter.sv
// Three-button up/down/clear event counter with debounce and an 8-digit multiplexed hex display.
// Optional leading-zero blanking is enabled by defining BUTTON_COUNTER_LZB_EN.
module button_event_counter #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 12500,
  parameter int SATURATE        = 0
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic [7:0]       AN,
  output logic [6:0]       seg,
  output logic             DP
);

  localparam int DIGITS = WIDTH / 4;
  localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW     = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [DBW-1:0]   DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]    SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [3:0]       DIGITS_L  = 4'(DIGITS);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  localparam int B_INC = 0;
  localparam int B_DEC = 1;
  localparam int B_CLR = 2;

  logic [2:0]     raw;
  logic [2:0]     sync_a;
  logic [2:0]     sync_b;
  logic [2:0]     level;
  logic [2:0]     level_q;
  logic [2:0]     armed;
  logic [2:0]     press;
  logic [1:0]     warm;
  logic [DBW-1:0] stable_cnt [3];

  assign raw = {btn_clr, btn_dec, btn_inc};

  // A button only becomes armed once its synchronised level has been seen low after reset,
  // so a button held through reset cannot register a press until it is released.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_q <= '0;
      armed   <= '0;
      warm    <= '0;
      // NOTE: the stability counters are individual flops, not a RAM, so they clear on reset.
      for (int i = 0; i < 3; i++) stable_cnt[i] <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_q <= level;
      warm    <= {warm[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == level[i]) begin
          stable_cnt[i] <= '0;
        end else if (stable_cnt[i] == DB_LAST) begin
          level[i]      <= sync_b[i];
          stable_cnt[i] <= '0;
        end else begin
          stable_cnt[i] <= stable_cnt[i] + DBW'(1);
        end
        if (warm[1] && !sync_b[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign press = level & ~level_q & armed;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block overrides it for the cycle.
      wrap <= 1'b0;
      if (press[B_CLR]) begin
        count <= '0;
      end else if (press[B_INC] && press[B_DEC]) begin
        count <= count;
      end else if (press[B_INC]) begin
        if (count == ALL_ONES) begin
          wrap <= 1'b1;
          if (SATURATE == 0) count <= '0;
        end else begin
          count <= count + WIDTH'(1);
        end
      end else if (press[B_DEC]) begin
        if (count == '0) begin
          wrap <= 1'b1;
          if (SATURATE == 0) count <= ALL_ONES;
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit;
  logic          tick;

  assign tick = (scan_cnt == SCAN_LAST);

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (tick) begin
      scan_cnt <= '0;
      digit    <= digit + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  logic [31:0] count_pad;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic        blank;
  logic        lz_blank;

  assign count_pad = 32'(count);

`ifdef BUTTON_COUNTER_LZB_EN
  logic [2:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (count_pad[4*i +: 4] != 4'h0) msd = 3'(i);
    end
  end

  assign lz_blank = (digit > msd);
`else
  assign lz_blank = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nibble = count_pad[{digit, 2'b00} +: 4];
    blank  = ({1'b0, digit} >= DIGITS_L) || lz_blank;
    glyph  = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  // Anodes and cathodes load together at the start of each slot.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      AN  <= 8'hFF;
      seg <= 7'h7F;
    end else if (tick) begin
      if (blank) begin
        AN  <= 8'hFF;
        seg <= 7'h7F;
      end else begin
        AN  <= ~(8'd1 << digit);
        seg <= glyph;
      end
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_button_event_counter.sv
// Scoreboard bench: a wrapping 16-bit counter and a saturating 4-bit counter share the buttons.
module tb_button_event_counter;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  logic btn_inc, btn_dec, btn_clr;

  logic [15:0] count0;
  logic        wrap0, dp0;
  logic [7:0]  an0;
  logic [6:0]  seg0;
  logic [3:0]  count1;
  logic        wrap1, dp1;
  logic [7:0]  an1;
  logic [6:0]  seg1;

  always #5 clk = ~clk;

  button_event_counter #(.WIDTH(16), .DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S), .SATURATE(0)) dut (
    .CLK100MHZ(clk), .RST(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
    .count(count0), .wrap(wrap0), .AN(an0), .seg(seg0), .DP(dp0)
  );

  button_event_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S), .SATURATE(1)) dut_sat (
    .CLK100MHZ(clk), .RST(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
    .count(count1), .wrap(wrap1), .AN(an1), .seg(seg1), .DP(dp1)
  );

  typedef struct {
    logic [15:0] c0;
    logic        w0;
    logic [3:0]  c1;
    logic        w1;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m0;
  logic [3:0]  m1;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Drive one button combination, predict both counters, then check latency, wrap pulse and hold.
  task automatic press(input logic inc, input logic dec, input logic clr,
                       input bit bounce, input int hold, input string tag);
    exp_t        e;
    logic [15:0] old0;
    logic [3:0]  old1;
    old0 = m0;
    old1 = m1;
    e.w0 = 1'b0;
    e.w1 = 1'b0;
    if (clr) begin
      m0 = '0;
      m1 = '0;
    end else if (inc && !dec) begin
      if (m0 == 16'hFFFF) begin m0 = '0; e.w0 = 1'b1; end else m0 = m0 + 16'd1;
      if (m1 == 4'hF) e.w1 = 1'b1; else m1 = m1 + 4'd1;
    end else if (dec && !inc) begin
      if (m0 == 16'h0000) begin m0 = 16'hFFFF; e.w0 = 1'b1; end else m0 = m0 - 16'd1;
      if (m1 == 4'h0) e.w1 = 1'b1; else m1 = m1 - 4'd1;
    end
    e.c0 = m0;
    e.c1 = m1;
    sb.push_back(e);

    if (bounce) begin
      btn_inc = 1'b1;
      wait_clks(1);
      btn_inc = 1'b0;
      wait_clks(1);
    end
    btn_inc = inc;
    btn_dec = dec;
    btn_clr = clr;

    wait_clks(D + 2);
    check({tag, "/early0"}, count0, old0);
    check({tag, "/early1"}, count1, old1);
    wait_clks(1);
    e = sb.pop_front();
    check({tag, "/count0"}, count0, e.c0);
    check({tag, "/wrap0"},  wrap0,  e.w0);
    check({tag, "/count1"}, count1, e.c1);
    check({tag, "/wrap1"},  wrap1,  e.w1);
    wait_clks(1);
    check({tag, "/wrap0_end"}, wrap0, 1'b0);
    check({tag, "/wrap1_end"}, wrap1, 1'b0);
    wait_clks(hold);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    btn_clr = 1'b0;
    wait_clks(D + 4);
    check({tag, "/held0"}, count0, e.c0);
    check({tag, "/held1"}, count1, e.c1);
  endtask

  // Align to the start of digit 0 and check all eight slots on both instances.
  task automatic scan_check();
    bit         found = 0;
    logic [7:0] prev;
    int         msd;
    logic       blank0, blank1;
    logic [7:0] exp_an;
    prev = an0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an0 == 8'hFE && prev != 8'hFE) found = 1;
      prev = an0;
    end
    check("scan_sync", found, 1'b1);
    msd = 0;
    for (int i = 1; i < 4; i++) if (((m0 >> (4 * i)) & 16'hF) != 0) msd = i;
    for (int d = 0; d < 8; d++) begin
      if (d > 0) wait_clks(S);
      blank0 = (d >= 4);
`ifdef BUTTON_COUNTER_LZB_EN
      if (d > msd) blank0 = 1'b1;
`endif
      blank1 = (d >= 1);
      exp_an = ~(8'd1 << d);
      check($sformatf("scan_an0_d%0d", d), an0, blank0 ? 8'hFF : exp_an);
      check($sformatf("scan_seg0_d%0d", d), seg0, blank0 ? 7'h7F : hex_glyph(4'((m0 >> (4 * d)) & 16'hF)));
      check($sformatf("scan_an1_d%0d", d), an1, blank1 ? 8'hFF : exp_an);
      check($sformatf("scan_seg1_d%0d", d), seg1, blank1 ? 7'h7F : hex_glyph(m1));
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    btn_clr = 1'b0;
    m0 = '0;
    m1 = '0;

    wait_clks(3);
    check("rst_count0", count0, 16'h0);
    check("rst_wrap0", wrap0, 1'b0);
    check("rst_an0", an0, 8'hFF);
    check("rst_seg0", seg0, 7'h7F);
    check("rst_dp0", dp0, 1'b1);
    check("rst_an1", an1, 8'hFF);

    rst = 1'b0;
    wait_clks(1);
    check("first_slot_wait", an0, 8'hFF);
    wait_clks(1);
    check("first_slot_an", an0, 8'hFE);
    check("first_slot_seg", seg0, 7'h40);
    wait_clks(6);

    press(1'b1, 1'b1, 1'b0, 1'b0, 2, "inc_dec_at0");
    press(1'b1, 1'b0, 1'b0, 1'b0, 42, "hold50");
    press(1'b1, 1'b0, 1'b0, 1'b1, 2, "bounce");
    press(1'b0, 1'b1, 1'b0, 1'b0, 2, "dec_a");
    press(1'b0, 1'b1, 1'b0, 1'b0, 2, "dec_b");
    press(1'b0, 1'b1, 1'b0, 1'b0, 2, "dec_at0");
    press(1'b1, 1'b0, 1'b0, 1'b0, 2, "inc_at_max");
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0, 1'b0, 2, $sformatf("inc_to5_%0d", i));
    press(1'b1, 1'b0, 1'b1, 1'b0, 2, "clr_inc");
    for (int i = 0; i < 163; i++) press(1'b1, 1'b0, 1'b0, 1'b0, 2, $sformatf("inc_run_%0d", i));

    scan_check();

    btn_inc = 1'b1;
    wait_clks(3);
    rst = 1'b1;
    m0 = '0;
    m1 = '0;
    wait_clks(1);
    check("midrst_count0", count0, 16'h0);
    check("midrst_an0", an0, 8'hFF);
    wait_clks(2);
    rst = 1'b0;
    wait_clks(20);
    check("held_after_rst0", count0, 16'h0);
    check("held_after_rst1", count1, 4'h0);
    btn_inc = 1'b0;
    wait_clks(10);
    press(1'b1, 1'b0, 1'b0, 1'b0, 2, "repress");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
